// File: rtl/es24.sv
// es24: twelve-digit decimal tabulator counter with add/subtract counting, carry phase and biquinary readout.
// Optional build macro ES24_END_AROUND_CARRY_EN adds end-around carry for true nines-complement subtraction.
module es24 (
    input  logic        clk,
    input  logic        reset,
    input  logic        aufnahme1,
    input  logic        aufnahme2,
    input  logic        umkehr1,
    input  logic        umkehr2,
    input  logic        minus1,
    input  logic        minus2,
    input  logic        loeschen,
    input  logic        zaehleranalyse,
    input  logic [12:0] timing,
    input  logic [12:1] digit_input,
    output logic [0:5]  ziffer_biqui1,
    output logic [0:5]  ziffer_biqui2,
    output logic [0:5]  ziffer_biqui3,
    output logic [0:5]  ziffer_biqui4,
    output logic [0:5]  ziffer_biqui5,
    output logic [0:5]  ziffer_biqui6,
    output logic [0:5]  ziffer_biqui7,
    output logic [0:5]  ziffer_biqui8,
    output logic [0:5]  ziffer_biqui9,
    output logic [0:5]  ziffer_biqui10,
    output logic [0:5]  ziffer_biqui11,
    output logic [0:5]  ziffer_biqui12,
    output logic        zaehleranalyse_out
);

    logic [3:0]  dig_q [1:12];
    logic [3:0]  dig_d [1:12];
    logic [0:5]  biq_q [1:12];
    logic [12:1] en_q, en_d, cy_q, cy_d;
    logic [12:0] timing_q, edge_w;
    logic        loeschen_q, clr_edge;
    logic        arm_add_q, arm_add_d, arm_sub_q, arm_sub_d;
    logic        minus_seen_q, minus_seen_d;
    logic        mode_add_q, mode_add_d, mode_sub_q, mode_sub_d;
    logic        unused_row10;
`ifdef ES24_END_AROUND_CARRY_EN
    logic        pend_q, pend_d;
`endif

    function automatic logic [0:5] biq(input logic [3:0] v);
        case (v)
            4'd0: biq = 6'b100000;
            4'd1: biq = 6'b010000;
            4'd2: biq = 6'b001000;
            4'd3: biq = 6'b000100;
            4'd4: biq = 6'b000010;
            4'd5: biq = 6'b100001;
            4'd6: biq = 6'b010001;
            4'd7: biq = 6'b001001;
            4'd8: biq = 6'b000101;
            4'd9: biq = 6'b000011;
            default: biq = 6'b000000;
        endcase
    endfunction

    assign edge_w       = timing & ~timing_q;
    assign clr_edge     = loeschen & ~loeschen_q;
    assign unused_row10 = edge_w[10];

    always_comb begin
        logic c, prev_cy, cnt_add, cnt_sub, cout;
        dig_d      = dig_q;
        en_d       = en_q;
        cy_d       = cy_q;
        mode_add_d = mode_add_q;
        mode_sub_d = mode_sub_q;
        c          = 1'b0;
        prev_cy    = 1'b0;
        cout       = 1'b0;
        cnt_add    = edge_w[9] ? arm_add_q : mode_add_q;
        cnt_sub    = edge_w[9] ? arm_sub_q : mode_sub_q;
`ifdef ES24_END_AROUND_CARRY_EN
        pend_d     = pend_q;
`endif
        if (clr_edge) begin
            dig_d      = '{default: '0};
            en_d       = '0;
            cy_d       = '0;
            mode_add_d = 1'b0;
            mode_sub_d = 1'b0;
`ifdef ES24_END_AROUND_CARRY_EN
            pend_d     = 1'b0;
`endif
        end else if (edge_w[11]) begin
            // a digit that wrapped during counting is at most 8, so flag and ripple never coincide
            for (int unsigned k = 1; k <= 12; k++) begin
                c = c | prev_cy;
                prev_cy = cy_q[k];
                if (c) begin
                    if (dig_q[k] == 4'd9) dig_d[k] = '0;
                    else begin
                        dig_d[k] = dig_q[k] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
            cout = c | cy_q[12];
`ifdef ES24_END_AROUND_CARRY_EN
            pend_d = cout & mode_sub_q;
`endif
            en_d = '0;
            cy_d = '0;
`ifdef ES24_END_AROUND_CARRY_EN
        end else if (pend_q) begin
            c = 1'b1;
            for (int unsigned k = 1; k <= 12; k++) begin
                if (c) begin
                    if (dig_q[k] == 4'd9) dig_d[k] = '0;
                    else begin
                        dig_d[k] = dig_q[k] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
            pend_d = 1'b0;
`endif
        end else if (|edge_w[9:0]) begin
            if (edge_w[9]) begin
                mode_add_d = arm_add_q;
                mode_sub_d = arm_sub_q;
            end
            if (cnt_add | cnt_sub) begin
                if (cnt_sub) begin
                    if (edge_w[9]) en_d = '1;
                    en_d = en_d & ~digit_input;
                end
                // subtract skips the row-0 step so an unpunched column adds 9, not 10
                if (!(cnt_sub && edge_w[0])) begin
                    for (int unsigned k = 1; k <= 12; k++) begin
                        if (en_d[k]) begin
                            if (dig_q[k] == 4'd9) begin
                                dig_d[k] = '0;
                                cy_d[k]  = 1'b1;
                            end else begin
                                dig_d[k] = dig_q[k] + 4'd1;
                            end
                        end
                    end
                end
                if (!cnt_sub) en_d = en_d | digit_input;
                if (edge_w[0]) en_d = '0;
            end
        end
    end

    always_comb begin
        arm_add_d    = arm_add_q;
        arm_sub_d    = arm_sub_q;
        minus_seen_d = minus_seen_q | (minus1 & minus2);
        if (edge_w[12]) begin
            arm_add_d    = aufnahme1 & aufnahme2;
            arm_sub_d    = (umkehr1 & umkehr2) ^ minus_seen_q;
            minus_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timing_q     <= '0;
            loeschen_q   <= 1'b0;
            dig_q        <= '{default: '0};
            biq_q        <= '{default: 6'b100000};
            en_q         <= '0;
            cy_q         <= '0;
            arm_add_q    <= 1'b0;
            arm_sub_q    <= 1'b0;
            minus_seen_q <= 1'b0;
            mode_add_q   <= 1'b0;
            mode_sub_q   <= 1'b0;
`ifdef ES24_END_AROUND_CARRY_EN
            pend_q       <= 1'b0;
`endif
        end else begin
            timing_q     <= timing;
            loeschen_q   <= loeschen;
            dig_q        <= dig_d;
            for (int unsigned k = 1; k <= 12; k++) biq_q[k] <= biq(dig_q[k]);
            en_q         <= en_d;
            cy_q         <= cy_d;
            arm_add_q    <= arm_add_d;
            arm_sub_q    <= arm_sub_d;
            minus_seen_q <= minus_seen_d;
            mode_add_q   <= mode_add_d;
            mode_sub_q   <= mode_sub_d;
`ifdef ES24_END_AROUND_CARRY_EN
            pend_q       <= pend_d;
`endif
        end
    end

    assign ziffer_biqui1      = biq_q[1];
    assign ziffer_biqui2      = biq_q[2];
    assign ziffer_biqui3      = biq_q[3];
    assign ziffer_biqui4      = biq_q[4];
    assign ziffer_biqui5      = biq_q[5];
    assign ziffer_biqui6      = biq_q[6];
    assign ziffer_biqui7      = biq_q[7];
    assign ziffer_biqui8      = biq_q[8];
    assign ziffer_biqui9      = biq_q[9];
    assign ziffer_biqui10     = biq_q[10];
    assign ziffer_biqui11     = biq_q[11];
    assign ziffer_biqui12     = biq_q[12];
    assign zaehleranalyse_out = zaehleranalyse & (dig_q[12] == 4'd9);

endmodule

// File: tb/tb_es24.sv
// Bench for es24: vector table of card operations plus randomized cards against an integer counter model.
module tb_es24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        aufnahme1 = 1'b0, aufnahme2 = 1'b0, umkehr1 = 1'b0, umkehr2 = 1'b0;
    logic        minus1 = 1'b0, minus2 = 1'b0, loeschen = 1'b0, zaehleranalyse = 1'b0;
    logic [12:0] timing = '0;
    logic [12:1] digit_input = '0;
    logic [0:5]  zb [1:12];
    logic        za_out;

    int n_cmp = 0;
    int n_bad = 0;
    longint model_cnt = 0;
    localparam longint M12 = 64'd1000000000000;

    always #5 clk = ~clk;

    es24 dut (
        .clk(clk), .reset(reset),
        .aufnahme1(aufnahme1), .aufnahme2(aufnahme2),
        .umkehr1(umkehr1), .umkehr2(umkehr2),
        .minus1(minus1), .minus2(minus2),
        .loeschen(loeschen), .zaehleranalyse(zaehleranalyse),
        .timing(timing), .digit_input(digit_input),
        .ziffer_biqui1(zb[1]), .ziffer_biqui2(zb[2]), .ziffer_biqui3(zb[3]),
        .ziffer_biqui4(zb[4]), .ziffer_biqui5(zb[5]), .ziffer_biqui6(zb[6]),
        .ziffer_biqui7(zb[7]), .ziffer_biqui8(zb[8]), .ziffer_biqui9(zb[9]),
        .ziffer_biqui10(zb[10]), .ziffer_biqui11(zb[11]), .ziffer_biqui12(zb[12]),
        .zaehleranalyse_out(za_out)
    );

    // kind: 0 unarmed, 1 add, 2 add+umkehr, 3 add+minus, 4 add+umkehr+minus
    typedef struct {
        bit     clr;
        int     kind;
        longint val;
        longint exp_eac;
        longint exp_plain;
    } vec_t;

    vec_t tbl [11];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int biq_dec(input logic [0:5] b);
        int idx = -1;
        int n = 0;
        for (int i = 0; i < 5; i++) if (b[i]) begin idx = i; n++; end
        if (n != 1) return -1;
        return idx + (b[5] ? 5 : 0);
    endfunction

    function automatic longint read_cnt();
        longint v = 0;
        longint p = 1;
        for (int k = 1; k <= 12; k++) begin
            int d = biq_dec(zb[k]);
            if (d < 0) return -1;
            v += longint'(d) * p;
            p *= 10;
        end
        return v;
    endfunction

    // Nines-complement subtraction: add (10^12-1-val), optional end-around carry.
    task automatic model_card(input int kind, input longint val);
        longint s;
        if (kind == 0) return;
        if (kind == 2 || kind == 3) begin
            s = model_cnt + (M12 - 1 - val);
            if (s >= M12) begin
`ifdef ES24_END_AROUND_CARRY_EN
                s = s - M12 + 1;
`else
                s = s - M12;
`endif
            end
            model_cnt = s;
        end else begin
            model_cnt = (model_cnt + val) % M12;
        end
    endtask

    task automatic pulse_row(input int r, input logic [12:1] holes);
        digit_input = holes;
        timing[r] = 1'b1;
        tick(4);
        timing[r] = 1'b0;
        digit_input = '0;
        tick(2);
    endtask

    task automatic pulse_clear();
        loeschen = 1'b1;
        tick(2);
        loeschen = 1'b0;
        tick(2);
    endtask

    task automatic run_card(input int kind, input longint val, input bit omit0, input int clr_row);
        int d [1:12];
        logic [12:1] holes;
        longint t = val;
        for (int k = 1; k <= 12; k++) begin
            d[k] = int'(t % 10);
            t = t / 10;
        end
        if (kind == 3 || kind == 4) begin
            minus1 = 1'b1; minus2 = 1'b1;
            tick(2);
            minus1 = 1'b0; minus2 = 1'b0;
            tick(1);
        end
        aufnahme1 = (kind != 0); aufnahme2 = (kind != 0);
        umkehr1 = (kind == 2 || kind == 4); umkehr2 = umkehr1;
        pulse_row(12, '0);
        aufnahme1 = 1'b0; aufnahme2 = 1'b0; umkehr1 = 1'b0; umkehr2 = 1'b0;
        for (int r = 9; r >= 0; r--) begin
            for (int k = 1; k <= 12; k++)
                holes[k] = (d[k] == r) && !(omit0 && r == 0);
            pulse_row(r, holes);
            if (r == clr_row) pulse_clear();
        end
        pulse_row(11, '0);
        tick(3);
    endtask

    initial begin
        longint exp_v, old_v;
        tbl[0]  = '{1'b1, 1, 64'd12345,        64'd12345,        64'd12345};
        tbl[1]  = '{1'b1, 1, 64'd999,          64'd999,          64'd999};
        tbl[2]  = '{1'b0, 1, 64'd1,            64'd1000,         64'd1000};
        tbl[3]  = '{1'b0, 2, 64'd1,            64'd999,          64'd998};
        tbl[4]  = '{1'b1, 1, 64'd3,            64'd3,            64'd3};
        tbl[5]  = '{1'b0, 2, 64'd5,            64'd999999999997, 64'd999999999997};
        tbl[6]  = '{1'b1, 1, 64'd10,           64'd10,           64'd10};
        tbl[7]  = '{1'b0, 3, 64'd4,            64'd6,            64'd5};
        tbl[8]  = '{1'b0, 0, 64'd777,          64'd6,            64'd5};
        tbl[9]  = '{1'b0, 1, 64'd12345,        64'd12351,        64'd12350};
        tbl[10] = '{1'b0, 4, 64'd100,          64'd12451,        64'd12450};

        tick(3);
        reset = 1'b0;
        tick(1);
        zaehleranalyse = 1'b1;
        #1;
        for (int k = 1; k <= 12; k++) check($sformatf("reset_biq%0d", k), longint'(zb[k]), longint'(6'b100000));
        check("reset_analysis", longint'(za_out), 0);
        zaehleranalyse = 1'b0;

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].clr) pulse_clear();
            run_card(tbl[i].kind, tbl[i].val, (i % 2) == 1, -1);
`ifdef ES24_END_AROUND_CARRY_EN
            exp_v = tbl[i].exp_eac;
`else
            exp_v = tbl[i].exp_plain;
`endif
            check($sformatf("vec%0d_count", i), read_cnt(), exp_v);
            zaehleranalyse = 1'b1;
            #1;
            check($sformatf("vec%0d_analysis", i), longint'(za_out), longint'((exp_v / 64'd100000000000) == 9));
            zaehleranalyse = 1'b0;
            #1;
            check($sformatf("vec%0d_analysis_off", i), longint'(za_out), 0);
            if (i == 0) begin
                check("vec0_d1_biq", longint'(zb[1]), longint'(6'b100001));
                check("vec0_d2_biq", longint'(zb[2]), longint'(6'b000010));
            end
            model_cnt = exp_v;
        end

        // Clear latency: outputs still old one cycle after the edge, zero the next.
        old_v = model_cnt;
        loeschen = 1'b1;
        tick(1);
        check("clr_lat1", read_cnt(), old_v);
        tick(1);
        check("clr_lat2", read_cnt(), 0);
        loeschen = 1'b0;
        tick(2);
        model_cnt = 0;

        run_card(1, 64'd12345, 1'b0, -1);
        check("pre_midclr", read_cnt(), 12345);
        run_card(1, 64'd55555, 1'b0, 5);
        check("midcard_clear", read_cnt(), 0);
        run_card(0, 64'd98765, 1'b0, -1);
        check("unarmed_after_clr", read_cnt(), 0);
        run_card(1, 64'd7, 1'b1, -1);
        check("resume_after_clr", read_cnt(), 7);
        model_cnt = 7;

        for (int i = 0; i < 40; i++) begin
            int kind;
            longint v;
            kind = int'($urandom_range(0, 4));
            v = 0;
            for (int k = 0; k < 12; k++) v = v * 10 + longint'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) begin
                pulse_clear();
                model_cnt = 0;
            end
            run_card(kind, v, $urandom_range(0, 1) == 1, -1);
            model_card(kind, v);
            check($sformatf("rand%0d_k%0d", i, kind), read_cnt(), model_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
